ub_port_arbiter: RTL and testbench
==================================

# ub_port_arbiter

Shares the single-port unified buffer (UB) between three burst requesters: DMA (0), systolic-array feeder (1) and VPU (2). A requester presents a base address, a beat count and a direction. The arbiter grants one requester at a time using round-robin priority. It then drives the UB port for one beat per cycle until the burst completes, and returns read data with one cycle of latency. It sits between `tpu_controller`-issued engine operations and the UB SRAM macro.

## Interface
Parameters:
- `DATA_W`, 64: UB word width.
- `ADDR_W`, 9: UB address width (512 words).
- `LEN_W`, 8: burst length field; beats = `len + 1`.

Ports (requester vectors are packed with requester i at slice i):
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  3  per-requester burst request, level.
- `we`  in  3  per-requester direction: 1 = write, 0 = read.
- `addr`  in  3*ADDR_W  per-requester burst base address.
- `len`  in  3*LEN_W  per-requester beats minus one.
- `wdata`  in  3*DATA_W  per-requester write data; sampled on its beats.
- `gnt`  out  3  one-cycle pulse on the first beat of a granted burst.
- `beat`  out  3  high on every cycle an access is issued for that requester.
- `done`  out  3  high on the last beat of that requester's burst.
- `rvalid`  out  3  read data valid; `beat & ~we` delayed one cycle.
- `rdata`  out  DATA_W  shared read data; `ub_rdata` passed through.
- `busy`  out  1  high while a burst is in progress.
- `owner`  out  2  index of the current burst owner; 0 when idle.
- `ub_en`  out  1  UB access enable.
- `ub_we`  out  1  UB write enable.
- `ub_addr`  out  ADDR_W  UB address.
- `ub_wdata`  out  DATA_W  UB write data.
- `ub_rdata`  in  DATA_W  UB read data, valid one cycle after a read `ub_en`.

## Operation
- States:
  - IDLE: no access in progress.
  - BURST: issuing beats.
- Arbitration happens in two situations:
  - in IDLE, whenever any `req` is high;
  - in BURST, on the last beat (`cnt == len_r`).
- Winner selection: search order is `rr`, `rr+1`, `rr+2`, all mod 3. The first index with a qualifying `req` wins.
- Request masking: `req[i]` is ignored in any cycle where `gnt[i]` = 1. A requester must drop `req` the cycle after `gnt` unless it wants another burst.
- On a win, the arbiter latches `owner`, `addr`, `len` and `we` into burst registers, sets `cnt` = 0 and sets `rr = (winner+1) mod 3`. The next state is BURST.
- If no request qualifies on the last beat, the next state is IDLE.
- Each BURST cycle:
  - `ub_en` = 1; `ub_we` = `we_r`; `ub_addr` = `cur_addr`; `ub_wdata` = the owner's `wdata` slice, combinational.
  - `beat[owner]` = 1.
  - `gnt[owner]` = 1 when `cnt` = 0.
  - `done[owner]` = 1 when `cnt == len_r`.
- Address progression: `cur_addr` increments by one per beat, modulo 2^ADDR_W (511 wraps to 0). `cnt` is LEN_W bits and counts 0 to `len_r`.
- Write data: for writes, the requester must present the word for beat k in the cycle `beat` is high for beat k.
- Read data: `rvalid[i]` is registered from `beat[i] & ~ub_we`. `rdata` is combinational from `ub_rdata`.
- In IDLE, all UB outputs and the `gnt`/`beat`/`done` outputs are 0.
- Reset (applies at any time, including mid-burst):
  - state = IDLE, `rr` = 0, `cnt` = 0;
  - all outputs 0, including `owner`;
  - the pending `rvalid` is discarded;
  - no partial burst is resumed after reset.

## Timing
- Grant latency: `req` high at cycle T in IDLE gives `gnt` and the first beat at T+1.
- A burst of N = `len` + 1 beats occupies cycles T+1 to T+N.
- Read: the `rvalid` for beat k arrives one cycle after that beat's `beat`. The last read `rvalid` is at T+N+1.
- Back-to-back: if another request qualifies on the last beat, the next burst's `gnt` and first beat come in the immediately following cycle, with no idle gap.
- Simultaneous requests are resolved only by `rr`. No requester is starved: any held `req` is granted within two other bursts.
- `busy` = (state == BURST), combinational from the state register.

## Test plan
- Single write: `req[0]`, `we` = 1, `addr` = 0x010, `len` = 3 at T → `gnt[0]` at T+1; `ub_addr` 0x010 to 0x013 on T+1 to T+4 with `ub_we` = 1; `done[0]` at T+4; IDLE at T+5.
- Read latency: `req[1]` read, `addr` = 0x020, `len` = 1; `ub_rdata` modelled as a 1-cycle SRAM → `rvalid[1]` at T+2 and T+3 carrying words 0x020 and 0x021.
- Contention: `req` = 3'b111 held continuously with `len` = 0, reset `rr` = 0 → grant order 0, 1, 2, 0, 1, 2 on consecutive cycles, no gaps.
- Round-robin after a win: `req[2]` alone is granted, then `req` = 3'b101 → requester 0 wins next (`rr` = 0 after granting 2).
- Address wrap: `addr` = 0x1FE, `len` = 3 → `ub_addr` sequence 0x1FE, 0x1FF, 0x000, 0x001.
- Reset mid-burst: `len` = 7, assert `rst_n` = 0 on beat 3 → next cycle `ub_en` = 0, `busy` = 0, `rvalid` = 0, `owner` = 0; after release, `req[1]` is granted ahead of `req[2]` (`rr` = 0).

Source files
------------

// File: rtl/ub_port_arbiter.sv
// Round-robin arbiter that shares the single-port unified buffer between the
// DMA, systolic feeder and VPU, issuing one beat per cycle for the granted burst.
module ub_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*LEN_W-1:0]    len,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            beat,
  output logic [2:0]            done,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [1:0]            owner,
  output logic                  ub_en,
  output logic                  ub_we,
  output logic [ADDR_W-1:0]     ub_addr,
  output logic [DATA_W-1:0]     ub_wdata,
  input  logic [DATA_W-1:0]     ub_rdata
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state;
  logic [1:0]          rr;
  logic [1:0]          owner_r;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    len_r;
  logic                we_r;
  logic [ADDR_W-1:0]   cur_addr;

  logic [2:0]          owner_hot;
  logic [2:0]          qual;
  logic                last;
  logic                arb;
  logic                win_found;
  logic [1:0]          win;
  logic [1:0]          c0, c1, c2;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic                sel_we;
  logic [DATA_W-1:0]   cur_wdata;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign busy      = (state == BURST);
  assign owner_hot = busy ? (3'b001 << owner_r) : 3'b000;
  assign last      = busy && (cnt == len_r);
  assign beat      = owner_hot;
  assign gnt       = (busy && (cnt == '0)) ? owner_hot : 3'b000;
  assign done      = last ? owner_hot : 3'b000;
  assign owner     = busy ? owner_r : 2'd0;

  assign ub_en     = busy;
  assign ub_we     = busy & we_r;
  assign ub_addr   = busy ? cur_addr : '0;
  assign ub_wdata  = busy ? cur_wdata : '0;
  assign rdata     = ub_rdata;

  // A requester whose grant is showing this cycle cannot win again off the same req level.
  assign qual = req & ~gnt;
  assign arb  = (state == IDLE) || last;

  assign c0 = rr;
  assign c1 = inc3(c0);
  assign c2 = inc3(c1);

  always_comb begin
    win       = c0;
    win_found = 1'b1;
    if (qual[c0])      win = c0;
    else if (qual[c1]) win = c1;
    else if (qual[c2]) win = c2;
    else               win_found = 1'b0;
  end

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_we    = 1'b0;
    cur_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (win == 2'(i)) begin
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_len  = len[i*LEN_W +: LEN_W];
        sel_we   = we[i];
      end
      if (owner_r == 2'(i)) cur_wdata = wdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 2'd0;
      owner_r  <= 2'd0;
      cnt      <= '0;
      len_r    <= '0;
      we_r     <= 1'b0;
      cur_addr <= '0;
      rvalid   <= 3'b000;
    end else begin
      rvalid <= beat & ~{3{we_r}};
      if (arb && win_found) begin
        state    <= BURST;
        owner_r  <= win;
        cur_addr <= sel_addr;
        len_r    <= sel_len;
        we_r     <= sel_we;
        cnt      <= '0;
        rr       <= inc3(win);
      end else if (last) begin
        state   <= IDLE;
        cnt     <= '0;
        owner_r <= 2'd0;
      end else if (busy) begin
        cnt      <= cnt + 1'b1;
        cur_addr <= cur_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Directed testbench for ub_port_arbiter with a one-cycle-latency SRAM model
// standing in for the unified buffer.
module tb_ub_port_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*LEN_W-1:0]  len;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt, beat, done, rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic [1:0]          owner;
  logic                ub_en, ub_we;
  logic [ADDR_W-1:0]   ub_addr;
  logic [DATA_W-1:0]   ub_wdata;
  logic [DATA_W-1:0]   ub_rdata;

  logic [DATA_W-1:0]   mem [512];

  int checks   = 0;
  int failures = 0;

  ub_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .len(len),
    .wdata(wdata), .gnt(gnt), .beat(beat), .done(done), .rvalid(rvalid),
    .rdata(rdata), .busy(busy), .owner(owner), .ub_en(ub_en), .ub_we(ub_we),
    .ub_addr(ub_addr), .ub_wdata(ub_wdata), .ub_rdata(ub_rdata)
  );

  always #5 clk = ~clk;

  // One-cycle read latency SRAM, initialised with an address-tagged pattern.
  always @(posedge clk) begin
    if (ub_en) begin
      if (ub_we) mem[ub_addr] <= ub_wdata;
      else       ub_rdata     <= mem[ub_addr];
    end
  end

  function automatic logic [DATA_W-1:0] pat(input int a);
    return 64'hCAFE_0000_0000_0000 | 64'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input int a, input int l);
    we[i] = w;
    addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    len[i*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 3'b000;
    tick();
    tick();
    checks++;
    if ({gnt, beat, done, rvalid, busy, owner, ub_en, ub_we} !== 17'h0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %h expected 0", {gnt, beat, done, rvalid, busy, owner, ub_en, ub_we});
    end
    checks++;
    if (ub_addr !== '0 || ub_wdata !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ub: got addr %h wdata %h expected 0", ub_addr, ub_wdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 'h010, 3);
    req = 3'b001;
    tick();
    req = 3'b000;
    checks++;
    if (gnt !== 3'b001) begin
      failures++;
      $display("[TB] FAIL write_gnt: got %b expected 001", gnt);
    end
    for (int k = 0; k < 4; k++) begin
      wdata[0 +: DATA_W] = 64'h1111_0000_0000_0000 + 64'(k);
      #1;
      checks++;
      if (ub_en !== 1'b1 || ub_we !== 1'b1 || ub_addr !== 9'(9'h010 + k) || beat !== 3'b001) begin
        failures++;
        $display("[TB] FAIL write_beat%0d: got en %b we %b addr %h beat %b expected 1 1 %h 001",
                 k, ub_en, ub_we, ub_addr, beat, 9'(9'h010 + k));
      end
      checks++;
      if (ub_wdata !== 64'h1111_0000_0000_0000 + 64'(k)) begin
        failures++;
        $display("[TB] FAIL write_data%0d: got %h expected %h", k, ub_wdata, 64'h1111_0000_0000_0000 + 64'(k));
      end
      checks++;
      if (done !== ((k == 3) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("[TB] FAIL write_done%0d: got %b expected %b", k, done, (k == 3) ? 3'b001 : 3'b000);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || ub_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_idle: got busy %b en %b expected 0 0", busy, ub_en);
    end
  endtask

  task automatic test_read_latency();
    set_req(1, 1'b0, 'h020, 1);
    req = 3'b010;
    tick();
    req = 3'b000;
    checks++;
    if (gnt !== 3'b010 || beat !== 3'b010 || ub_we !== 1'b0 || rvalid !== 3'b000 || owner !== 2'd1) begin
      failures++;
      $display("[TB] FAIL read_first: got gnt %b beat %b we %b rvalid %b owner %0d expected 010 010 0 000 1",
               gnt, beat, ub_we, rvalid, owner);
    end
    tick();
    checks++;
    if (rvalid !== 3'b010 || rdata !== pat('h020) || done !== 3'b010) begin
      failures++;
      $display("[TB] FAIL read_word0: got rvalid %b rdata %h done %b expected 010 %h 010", rvalid, rdata, done, pat('h020));
    end
    tick();
    checks++;
    if (rvalid !== 3'b010 || rdata !== pat('h021) || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_word1: got rvalid %b rdata %h busy %b expected 010 %h 0", rvalid, rdata, busy, pat('h021));
    end
    tick();
    checks++;
    if (rvalid !== 3'b000) begin
      failures++;
      $display("[TB] FAIL read_end: got rvalid %b expected 000", rvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b0, 'h100, 0);
    set_req(1, 1'b0, 'h110, 0);
    set_req(2, 1'b0, 'h120, 0);
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = 3'b001 << (i % 3);
      checks++;
      if (gnt !== exp || busy !== 1'b1 || done !== exp) begin
        failures++;
        $display("[TB] FAIL contention%0d: got gnt %b busy %b done %b expected %b 1 %b", i, gnt, busy, done, exp, exp);
      end
    end
    req = 3'b000;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL contention_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_rr_after_win();
    set_req(0, 1'b0, 'h030, 0);
    set_req(2, 1'b0, 'h0A0, 0);
    req = 3'b100;
    tick();
    req = 3'b000;
    checks++;
    if (gnt !== 3'b100) begin
      failures++;
      $display("[TB] FAIL rr_first: got %b expected 100", gnt);
    end
    tick();
    req = 3'b101;
    tick();
    req = 3'b000;
    checks++;
    if (gnt !== 3'b001 || ub_addr !== 9'h030) begin
      failures++;
      $display("[TB] FAIL rr_second: got gnt %b addr %h expected 001 030", gnt, ub_addr);
    end
    tick();
  endtask

  task automatic test_addr_wrap();
    logic [ADDR_W-1:0] exp_addr [4];
    exp_addr[0] = 9'h1FE;
    exp_addr[1] = 9'h1FF;
    exp_addr[2] = 9'h000;
    exp_addr[3] = 9'h001;
    set_req(0, 1'b1, 'h1FE, 3);
    req = 3'b001;
    tick();
    req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ub_addr !== exp_addr[k] || ub_en !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrap%0d: got addr %h en %b expected %h 1", k, ub_addr, ub_en, exp_addr[k]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    set_req(1, 1'b0, 'h040, 7);
    req = 3'b010;
    tick();
    req = 3'b000;
    tick();
    tick();
    tick();
    checks++;
    if (beat !== 3'b010 || ub_addr !== 9'h043) begin
      failures++;
      $display("[TB] FAIL midrst_beat3: got beat %b addr %h expected 010 043", beat, ub_addr);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (ub_en !== 1'b0 || busy !== 1'b0 || rvalid !== 3'b000 || owner !== 2'd0) begin
      failures++;
      $display("[TB] FAIL midrst_cleared: got en %b busy %b rvalid %b owner %0d expected 0 0 000 0",
               ub_en, busy, rvalid, owner);
    end
    rst_n = 1'b1;
    set_req(1, 1'b0, 'h050, 0);
    set_req(2, 1'b0, 'h060, 0);
    req = 3'b110;
    tick();
    req = 3'b000;
    checks++;
    if (gnt !== 3'b010 || owner !== 2'd1 || ub_addr !== 9'h050) begin
      failures++;
      $display("[TB] FAIL midrst_regrant: got gnt %b owner %0d addr %h expected 010 1 050", gnt, owner, ub_addr);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_idle: got busy %b expected 0", busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = pat(i);
    ub_rdata = '0;
    rst_n = 1'b0;
    req   = 3'b000;
    we    = 3'b000;
    addr  = '0;
    len   = '0;
    wdata = '0;
    test_reset();
    test_single_write();
    test_read_latency();
    test_back_to_back();
    test_rr_after_win();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
